// File: rtl/in256_out1536_flex_if.sv
// Stream bus shared by the input and output sides of in256_out1536_flex.
// W selects the tdata width; master drives the payload, slave drives tready.
interface in256_out1536_flex_if #(
    parameter int unsigned W = 256
) ();
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tlast;
    logic         tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/in256_out1536_flex.sv
// Packs 256-bit beats carrying 64/128/256 useful bits into 1536-bit output words.
// Optional replica checking of the dropped upper lanes: IN256_OUT1536_REPLICA_CHECK_EN.
module in256_out1536_flex #(
    parameter int unsigned OUT_W  = 1536,
    parameter int unsigned LANE_W = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [2:0]                  shift_ctrl,
    in256_out1536_flex_if.slave         s_axis,
    in256_out1536_flex_if.master        m_axis,
    output logic                        err_replica
);
    localparam int unsigned IN_W   = 256;
    localparam int unsigned SLOTS  = OUT_W / LANE_W;
    localparam int unsigned SLOT_W = $clog2(SLOTS + 1);
    localparam int unsigned SH_W   = $clog2(OUT_W);

    localparam logic [1:0] MODE_64  = 2'd0;
    localparam logic [1:0] MODE_128 = 2'd1;
    localparam logic [1:0] MODE_256 = 2'd2;

    logic [1:0]        mode_q, mode_d, mode_eff;
    logic [SLOT_W-1:0] slot_q, slot_d, inc;
    logic [SLOT_W:0]   slot_sum;
    logic [OUT_W-1:0]  acc_q, acc_d, merged;
    logic [OUT_W-1:0]  tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic [IN_W-1:0]   beat;
    logic              completing, ready_c, accept;

    // Mode applies from the first beat of a word; later beats reuse the latched mode.
    always_comb begin
        mode_eff = mode_q;
        if (slot_q == '0) begin
            if (shift_ctrl[2])      mode_eff = MODE_256;
            else if (shift_ctrl[1]) mode_eff = MODE_128;
            else                    mode_eff = MODE_64;
        end

        beat = '0;
        inc  = SLOT_W'(IN_W / LANE_W);
        case (mode_eff)
            MODE_64: begin
                beat[63:0] = s_axis.tdata[63:0];
                inc        = SLOT_W'(1);
            end
            MODE_128: begin
                beat[127:0] = s_axis.tdata[127:0];
                inc         = SLOT_W'(2);
            end
            default: begin
                beat = s_axis.tdata;
                inc  = SLOT_W'(IN_W / LANE_W);
            end
        endcase

        slot_sum   = {1'b0, slot_q} + {1'b0, inc};
        completing = (slot_sum >= (SLOT_W + 1)'(SLOTS)) | s_axis.tlast;
        // Stall only when this beat would overwrite a word still waiting at the output.
        ready_c    = ~(tvalid_q & ~m_axis.tready & completing);
        accept     = s_axis.tvalid & ready_c;
        merged     = acc_q | (OUT_W'(beat) << (SH_W'(slot_q) * SH_W'(LANE_W)));
    end

    assign s_axis.tready = ready_c;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;

    always_comb begin
        mode_d   = mode_q;
        slot_d   = slot_q;
        acc_d    = acc_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;

        if (tvalid_q & m_axis.tready) tvalid_d = 1'b0;

        if (accept) begin
            mode_d = mode_eff;
            if (completing) begin
                tdata_d  = merged;
                tvalid_d = 1'b1;
                tlast_d  = s_axis.tlast;
                acc_d    = '0;
                slot_d   = '0;
            end else begin
                acc_d  = merged;
                slot_d = slot_sum[SLOT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= MODE_256;
            slot_q   <= '0;
            acc_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            slot_q   <= slot_d;
            acc_q    <= acc_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

`ifdef IN256_OUT1536_REPLICA_CHECK_EN
    logic err_q, mismatch;

    // Upper lanes must replicate the useful bits of the current mode.
    always_comb begin
        mismatch = 1'b0;
        case (mode_eff)
            MODE_64:  mismatch = (s_axis.tdata[127:64]  != s_axis.tdata[63:0]) |
                                 (s_axis.tdata[191:128] != s_axis.tdata[63:0]) |
                                 (s_axis.tdata[255:192] != s_axis.tdata[63:0]);
            MODE_128: mismatch = (s_axis.tdata[255:128] != s_axis.tdata[127:0]);
            default:  mismatch = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_q | (accept & mismatch);
    end

    assign err_replica = err_q;
`else
    assign err_replica = 1'b0;
`endif

endmodule

// File: tb/tb_in256_out1536_flex.sv
// Self-checking bench for in256_out1536_flex: table vectors, corner sequences and
// randomized traffic checked against a bit-position packing model.
module tb_in256_out1536_flex;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] shift_ctrl;
    logic       err_replica;

    in256_out1536_flex_if #(.W(256))  s_if ();
    in256_out1536_flex_if #(.W(1536)) m_if ();

    in256_out1536_flex dut (
        .clk         (clk),
        .rst         (rst),
        .shift_ctrl  (shift_ctrl),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .err_replica (err_replica)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1535:0] data;
        logic          last;
    } word_t;

    typedef struct {
        logic [2:0] sc;
        int         nbeats;
        logic       last;
        int         exp_words;
        logic       exp_tlast;
        int         exp_fill;
    } vec_t;

    // Reference model: bit position within the word, width of the current word.
    word_t         q[$];
    logic [1535:0] m_word;
    int            m_pos;
    int            m_w;
    logic          m_err;

    int            errors = 0;
    int            checks = 0;
    int            words_seen = 0;
    logic [1535:0] last_data;
    logic          last_tlast;

`ifdef IN256_OUT1536_REPLICA_CHECK_EN
    localparam logic CHECK_ON = 1'b1;
`else
    localparam logic CHECK_ON = 1'b0;
`endif

    function automatic int dec(input logic [2:0] sc);
        if (sc[2]) return 256;
        if (sc[1]) return 128;
        return 64;
    endfunction

    function automatic logic [255:0] mk(input int w, input logic [63:0] v);
        logic [127:0] h;
        h = {~v, v};
        if (w == 64)  return {v, v, v, v};
        if (w == 128) return {h, h};
        return {v ^ 64'hA5A5_5A5A_0F0F_F0F0, ~v, v + 64'd1, v};
    endfunction

    task automatic chk1(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [1535:0] act, input logic [1535:0] exp);
        int idx;
        checks++;
        if (act !== exp) begin
            errors++;
            idx = 0;
            for (int i = 0; i < 24; i++) begin
                if (act[i*64 +: 64] !== exp[i*64 +: 64]) begin
                    idx = i;
                    break;
                end
            end
            $display("FAIL %s lane %0d: got %h expected %h at %0t", nm, idx,
                     act[idx*64 +: 64], exp[idx*64 +: 64], $time);
        end
    endtask

    task automatic model_accept(input logic [255:0] d, input logic l, input logic [2:0] sc);
        int  w;
        logic mis;
        w   = (m_pos == 0) ? dec(sc) : m_w;
        m_w = w;
        mis = 1'b0;
        if (w == 64) begin
            for (int j = 1; j < 4; j++) if (d[j*64 +: 64] != d[63:0]) mis = 1'b1;
        end else if (w == 128) begin
            if (d[255:128] != d[127:0]) mis = 1'b1;
        end
        if (CHECK_ON && mis) m_err = 1'b1;
        for (int i = 0; i < w; i++) m_word[m_pos + i] = d[i];
        m_pos += w;
        if (m_pos >= 1536 || l) begin
            q.push_back('{data: m_word, last: l});
            m_word = '0;
            m_pos  = 0;
        end
    endtask

    task automatic check_outputs();
        chk1("m_tvalid", 64'(m_if.tvalid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chkw("m_tdata", m_if.tdata, q[0].data);
            chk1("m_tlast", 64'(m_if.tlast), 64'(q[0].last));
        end
        chk1("err_replica", 64'(err_replica), 64'(m_err));
    endtask

    // One clock: drive at negedge, predict handshakes, step the model, check at next negedge.
    task automatic cyc(input logic v, input logic [255:0] d, input logic l,
                       input logic [2:0] sc, input logic mr, output logic acc);
        int   w;
        logic exp_rdy;
        s_if.tvalid = v;
        s_if.tdata  = d;
        s_if.tlast  = l;
        shift_ctrl  = sc;
        m_if.tready = mr;
        #1;
        w       = (m_pos == 0) ? dec(sc) : m_w;
        exp_rdy = !((q.size() != 0) && !mr && ((m_pos + w >= 1536) || l));
        chk1("s_tready", 64'(s_if.tready), 64'(exp_rdy));
        acc = v && s_if.tready;
        if (m_if.tvalid && mr) begin
            words_seen++;
            last_data  = m_if.tdata;
            last_tlast = m_if.tlast;
            if (q.size() != 0) void'(q.pop_front());
        end
        if (acc) model_accept(d, l, sc);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send_beat(input logic [255:0] d, input logic l, input logic [2:0] sc,
                             input logic mr);
        logic acc;
        for (int n = 0; n < 50; n++) begin
            cyc(1'b1, d, l, sc, mr, acc);
            if (acc) return;
        end
        chk1("send timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n, input logic mr);
        logic acc;
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 3'b100, mr, acc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            idle(1, 1'b1);
            n++;
        end
        chk1("drain", 64'(m_if.tvalid), 64'd0);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        q.delete();
        m_word = '0;
        m_pos  = 0;
        m_w    = 256;
        m_err  = 1'b0;
        #1;
        chk1("rst m_tvalid", 64'(m_if.tvalid), 64'd0);
        chk1("rst m_tlast", 64'(m_if.tlast), 64'd0);
        chkw("rst m_tdata", m_if.tdata, '0);
        chk1("rst err_replica", 64'(err_replica), 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t          vecs[7];
    logic [255:0]  d;
    logic          acc;
    int            w0, b;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{sc: 3'b100, nbeats: 6,  last: 1'b0, exp_words: 1, exp_tlast: 1'b0, exp_fill: 1536};
        vecs[1] = '{sc: 3'b001, nbeats: 24, last: 1'b0, exp_words: 1, exp_tlast: 1'b0, exp_fill: 1536};
        vecs[2] = '{sc: 3'b010, nbeats: 5,  last: 1'b1, exp_words: 1, exp_tlast: 1'b1, exp_fill: 640};
        vecs[3] = '{sc: 3'b010, nbeats: 12, last: 1'b1, exp_words: 1, exp_tlast: 1'b1, exp_fill: 1536};
        vecs[4] = '{sc: 3'b001, nbeats: 3,  last: 1'b1, exp_words: 1, exp_tlast: 1'b1, exp_fill: 192};
        vecs[5] = '{sc: 3'b110, nbeats: 2,  last: 1'b1, exp_words: 1, exp_tlast: 1'b1, exp_fill: 512};
        vecs[6] = '{sc: 3'b000, nbeats: 1,  last: 1'b1, exp_words: 1, exp_tlast: 1'b1, exp_fill: 64};

        rst         = 1'b0;
        shift_ctrl  = 3'b100;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        last_data   = '0;
        last_tlast  = 1'b0;
        #2;
        do_reset();

        // Table vectors: each entry closes exactly one word.
        for (int e = 0; e < 7; e++) begin
            w0 = words_seen;
            for (int k = 0; k < vecs[e].nbeats; k++)
                send_beat(mk(dec(vecs[e].sc), 64'h00B0 + 64'(k) + (64'(e) << 16)),
                          vecs[e].last && (k == vecs[e].nbeats - 1), vecs[e].sc, 1'b1);
            drain();
            chk1("tbl words", 64'(words_seen - w0), 64'(vecs[e].exp_words));
            chk1("tbl tlast", 64'(last_tlast), 64'(vecs[e].exp_tlast));
            chkw("tbl fill", last_data >> vecs[e].exp_fill, '0);
        end

        // Output held for 20 cycles: second word stalls on its completing beat.
        b = 0;
        for (int c = 0; c < 20; c++) begin
            cyc(1'b1, mk(256, 64'hC00 + 64'(b)), 1'b0, 3'b100, 1'b0, acc);
            if (acc) b++;
        end
        chk1("bp accepted", 64'(b), 64'd11);
        chk1("bp stalled", 64'(s_if.tready), 64'd0);
        w0 = words_seen;
        send_beat(mk(256, 64'hC00 + 64'd11), 1'b0, 3'b100, 1'b1);
        drain();
        chk1("bp words", 64'(words_seen - w0), 64'd2);

        // Mode change mid-word is ignored until the next word.
        w0 = words_seen;
        for (int k = 0; k < 2; k++) send_beat(mk(256, 64'hD00 + 64'(k)), 1'b0, 3'b100, 1'b1);
        for (int k = 0; k < 4; k++) begin
            d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            send_beat(d, 1'b0, 3'b001, 1'b1);
        end
        drain();
        chk1("mode latch words", 64'(words_seen - w0), 64'd1);
        for (int k = 0; k < 23; k++) send_beat(mk(64, 64'hE00 + 64'(k)), 1'b0, 3'b001, 1'b1);
        chk1("w64 no early word", 64'(m_if.tvalid), 64'd0);
        send_beat(mk(64, 64'hE00 + 64'd23), 1'b0, 3'b001, 1'b1);
        drain();
        chk1("w64 words", 64'(words_seen - w0), 64'd2);

        // Replica mismatch, then reset in the middle of a word.
        d = mk(64, 64'h1234_5678_9ABC_DEF0);
        d[191:128] = 64'hFFFF_0000_FFFF_0000;
        send_beat(d, 1'b0, 3'b001, 1'b1);
        idle(3, 1'b1);
        chk1("err sticky", 64'(err_replica), 64'(CHECK_ON));
        send_beat(mk(64, 64'h77), 1'b0, 3'b001, 1'b1);
        send_beat(mk(64, 64'h78), 1'b0, 3'b001, 1'b1);
        do_reset();
        w0 = words_seen;
        for (int k = 0; k < 6; k++) send_beat(mk(256, 64'hF00 + 64'(k)), 1'b0, 3'b100, 1'b1);
        drain();
        chk1("post-rst words", 64'(words_seen - w0), 64'd1);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            logic [2:0] sc;
            logic       v, l, mr;
            int         w;
            sc = 3'($urandom_range(0, 7));
            v  = ($urandom_range(0, 3) != 0);
            mr = ($urandom_range(0, 3) != 0);
            l  = ($urandom_range(0, 9) == 0);
            w  = (m_pos == 0) ? dec(sc) : m_w;
            d  = mk(w, {$urandom, $urandom});
            if ($urandom_range(0, 49) == 0) d[200] = ~d[200];
            cyc(v, d, l, sc, mr, acc);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
